cmd_page_splitter: RTL and testbench

Parametrised command splitter between the AXI-side command front end and the RPC DRAM command scheduler. It accepts one burst command of up to 2^InLenWidth words and emits a sequence of sub-commands. No sub-command crosses a DRAM page boundary of PageWords words, and none exceeds 2^DramLenWidth beats. Unlike the two-way splitter it replaces, it handles any number of splits, runs at full chunk throughput, and tags each chunk with first/last/index for the write- and read-data realigners.

---
 rtl/cmd_page_splitter.sv | 126 ++++++++++++
 tb/tb_cmd_page_splitter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_page_splitter.sv
// cmd_page_splitter: cuts one burst command into page-safe DRAM chunks
// tagged with first/last/index, at one chunk per cycle.
module cmd_page_splitter #(
  parameter int DramAddrWidth = 20,
  parameter int InLenWidth    = 8,
  parameter int DramLenWidth  = 6,
  parameter int PageWords     = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [DramAddrWidth-1:0] cmd_addr_i,
  input  logic [InLenWidth-1:0]    cmd_len_i,
  input  logic                     cmd_write_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [DramAddrWidth-1:0] cmd_addr_o,
  output logic [DramLenWidth-1:0]  cmd_len_o,
  output logic                     cmd_write_o,
  output logic                     cmd_first_o,
  output logic                     cmd_last_o,
  output logic [InLenWidth-1:0]    cmd_idx_o
);

  localparam int W = (InLenWidth > DramAddrWidth ?
                      InLenWidth : DramAddrWidth) + 1;

  localparam logic [W-1:0] PageW    = W'(PageWords);
  localparam logic [W-1:0] PageMask = PageW - W'(1);
  localparam logic [W-1:0] MaxChunk = W'(1) << DramLenWidth;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e state_q, state_d;

  logic [DramAddrWidth-1:0] addr_q;
  logic [InLenWidth-1:0]    rem_q;
  logic                     wr_q;
  logic [InLenWidth-1:0]    idx_q;

  logic [W-1:0] room;
  logic [W-1:0] need;
  logic [W-1:0] chunk;
  logic         last;
  logic         valid;
  logic         ready;
  logic         load;
  logic         adv;

  // Chunk size: smallest of what is left, page room and max burst
  always_comb begin
    room  = PageW - (W'(addr_q) & PageMask);
    need  = W'(rem_q) + W'(1);
    chunk = need;
    if (room < chunk) chunk = room;
    if (MaxChunk < chunk) chunk = MaxChunk;
    last  = (chunk == need);
  end

  assign cmd_valid_o = valid;
  assign cmd_ready_o = ready;
  assign cmd_addr_o  = addr_q;
  assign cmd_len_o   = DramLenWidth'(chunk - W'(1));
  assign cmd_write_o = wr_q;
  assign cmd_first_o = (idx_q == '0);
  assign cmd_last_o  = last;
  assign cmd_idx_o   = idx_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, handshake and register-update strobes
  always_comb begin
    state_d = state_q;
    valid   = 1'b0;
    ready   = 1'b0;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = rst_ni;
        if (rst_ni && cmd_valid_i) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        valid = 1'b1;
        ready = rst_ni & last & cmd_ready_i;
        if (cmd_ready_i) begin
          if (!last)            adv     = 1'b1;
          else if (cmd_valid_i) load    = 1'b1;
          else                  state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Held command: load a new one or step past the issued chunk
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0;
      rem_q  <= '0;
      wr_q   <= 1'b0;
      idx_q  <= '0;
    end else if (load) begin
      addr_q <= cmd_addr_i;
      rem_q  <= cmd_len_i;
      wr_q   <= cmd_write_i;
      idx_q  <= '0;
    end else if (adv) begin
      addr_q <= addr_q + DramAddrWidth'(chunk);
      rem_q  <= rem_q - InLenWidth'(chunk);
      idx_q  <= idx_q + InLenWidth'(1);
    end
  end

endmodule

// File: tb/tb_cmd_page_splitter.sv
// tb_cmd_page_splitter: random and directed stimulus checked against a
// beat-walking reference of the chunking rules.
module tb_cmd_page_splitter;

  localparam int PAGE = 64;
  localparam int MAXC = 64;

  typedef struct {
    logic [19:0] addr;
    logic [5:0]  len;
    logic        wr;
    logic        first;
    logic        last;
    logic [7:0]  idx;
  } chunk_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [19:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic        cmd_write_i;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [19:0] cmd_addr_o;
  logic [5:0]  cmd_len_o;
  logic        cmd_write_o;
  logic        cmd_first_o;
  logic        cmd_last_o;
  logic [7:0]  cmd_idx_o;

  int checks = 0;
  int passed = 0;
  bit rnd_rdy = 0;
  bit rst_seen = 0;

  chunk_t q[$];
  chunk_t gq[$];

  cmd_page_splitter dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_write_i (cmd_write_i),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_addr_o  (cmd_addr_o),
    .cmd_len_o   (cmd_len_o),
    .cmd_write_o (cmd_write_o),
    .cmd_first_o (cmd_first_o),
    .cmd_last_o  (cmd_last_o),
    .cmd_idx_o   (cmd_idx_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic push_chunk(input logic [19:0] a, input int cl,
                            input logic w, input logic lst);
    chunk_t c;
    c.addr  = a;
    c.len   = 6'(cl - 1);
    c.wr    = w;
    c.first = (gq.size() == 0);
    c.last  = lst;
    c.idx   = 8'(gq.size());
    gq.push_back(c);
  endtask

  // Walk the burst beat by beat; a new chunk opens at a page start
  // or once the current chunk holds the maximum burst
  task automatic split(input logic [19:0] a0, input logic [7:0] l,
                       input logic w);
    int n;
    int cl;
    logic [19:0] a;
    logic [19:0] start;
    n = int'(l) + 1;
    cl = 0;
    start = a0;
    gq.delete();
    for (int b = 0; b < n; b++) begin
      a = a0 + 20'(b);
      if (b != 0 && ((int'(a) % PAGE) == 0 || cl == MAXC)) begin
        push_chunk(start, cl, w, 1'b0);
        cl = 0;
        start = a;
      end
      cl++;
    end
    push_chunk(start, cl, w, 1'b1);
  endtask

  // Ready source: always 1, or random when backpressure is wanted
  initial begin
    cmd_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cmd_ready_i = rnd_rdy ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Compare process: every negedge, check outputs and advance the model
  initial begin
    bit exp_rdy;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        chk("ready_in_rst", 32'(cmd_ready_o), 0);
        if (rst_seen) begin
          chk("rst_valid", 32'(cmd_valid_o), 0);
          chk("rst_addr",  32'(cmd_addr_o),  0);
          chk("rst_len",   32'(cmd_len_o),   0);
          chk("rst_write", 32'(cmd_write_o), 0);
          chk("rst_first", 32'(cmd_first_o), 1);
          chk("rst_last",  32'(cmd_last_o),  1);
          chk("rst_idx",   32'(cmd_idx_o),   0);
        end
        rst_seen = 1;
        q.delete();
      end else begin
        rst_seen = 0;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && cmd_ready_i);
        chk("valid", 32'(cmd_valid_o), 32'(q.size() != 0));
        chk("ready", 32'(cmd_ready_o), 32'(exp_rdy));
        if (q.size() != 0 && cmd_valid_o) begin
          chk("addr",  32'(cmd_addr_o),  32'(q[0].addr));
          chk("len",   32'(cmd_len_o),   32'(q[0].len));
          chk("write", 32'(cmd_write_o), 32'(q[0].wr));
          chk("first", 32'(cmd_first_o), 32'(q[0].first));
          chk("last",  32'(cmd_last_o),  32'(q[0].last));
          chk("idx",   32'(cmd_idx_o),   32'(q[0].idx));
        end
        if (q.size() != 0 && cmd_ready_i) void'(q.pop_front());
        if (cmd_valid_i && exp_rdy) begin
          split(cmd_addr_i, cmd_len_i, cmd_write_i);
          foreach (gq[i]) q.push_back(gq[i]);
        end
      end
    end
  end

  task automatic send(input logic [19:0] a, input logic [7:0] l,
                      input logic w);
    cmd_addr_i  = a;
    cmd_len_i   = l;
    cmd_write_i = w;
    cmd_valid_i = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    $display("FAIL send_timeout: no input handshake for addr %0h", a);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmd_valid_i = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) return;
    end
    checks++;
    $display("FAIL drain_timeout: %0d chunks still pending", q.size());
  endtask

  initial begin
    logic [19:0] pa[5];
    logic [5:0]  pl[5];
    pa[0] = 20'h0003C; pl[0] = 6'd3;
    pa[1] = 20'h00040; pl[1] = 6'd63;
    pa[2] = 20'h00080; pl[2] = 6'd63;
    pa[3] = 20'h000C0; pl[3] = 6'd63;
    pa[4] = 20'h00100; pl[4] = 6'd59;
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_len_i   = '0;
    cmd_write_i = 1'b0;

    split(20'h0003C, 8'd255, 1'b1);
    chk("pin5_n", 32'(gq.size()), 5);
    for (int i = 0; i < 5; i++) begin
      chk("pin5_addr", 32'(gq[i].addr), 32'(pa[i]));
      chk("pin5_len",  32'(gq[i].len),  32'(pl[i]));
    end
    chk("pin5_last", 32'(gq[4].last), 1);
    chk("pin5_wr",   32'(gq[4].wr),   1);
    split(20'hFFFF0, 8'd31, 1'b0);
    chk("pinw_n",     32'(gq.size()), 2);
    chk("pinw_addr1", 32'(gq[1].addr), 0);
    chk("pinw_len0",  32'(gq[0].len), 15);
    split(20'h00010, 8'd15, 1'b0);
    chk("pin1_n",     32'(gq.size()), 1);
    chk("pin1_fl",    32'({gq[0].first, gq[0].last}), 3);

    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;

    send(20'h00010, 8'd15, 1'b0);
    idle();
    send(20'h0003C, 8'd255, 1'b1);
    idle();
    send(20'hFFFF0, 8'd31, 1'b0);
    idle();

    rnd_rdy = 1;
    send(20'h0003C, 8'd255, 1'b0);
    idle();
    rnd_rdy = 0;
    @(posedge clk);
    #1;

    send(20'h00100, 8'd3, 1'b1);
    send(20'h00200, 8'd7, 1'b0);
    idle();

    send(20'h0003C, 8'd255, 1'b1);
    cmd_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    send(20'h00040, 8'd5, 1'b0);
    idle();

    for (int k = 0; k < 40; k++) begin
      logic [19:0] a;
      rnd_rdy = (k % 3) != 0;
      a = ($urandom_range(0, 3) == 0) ?
          20'hFFFFF - 20'($urandom_range(0, 80)) : 20'($urandom);
      send(a, 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
